// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed big-endian data memory behind a request/ack
// handshake with a programmable acknowledge latency.
// Optional feature macro DMEM_MMIO_EN adds a character-output port
// (byte store to STDOUT_ADDR) and a sticky program-exit flag (store to EXIT_ADDR).
module dmem_ctrl #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 65536,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0800_0000,
    parameter int                    LATENCY     = 1,
    parameter logic [ADDR_WIDTH-1:0] STDOUT_ADDR = 32'hf000_0000,
    parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR   = 32'hff00_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MREQ,
    input  logic                  WRITE,
    input  logic [1:0]            SIZE,
    input  logic [ADDR_WIDTH-1:0] DAD,
    input  logic [31:0]           WDT,
    output logic [31:0]           RDT,
    output logic                  ACKD_n,
    output logic                  ERR,
    output logic [ADDR_WIDTH-1:0] MAX_ADDR,
    output logic                  EXIT,
    output logic                  STDOUT_VALID,
    output logic [7:0]            STDOUT_CHAR
);
    localparam int AW = ADDR_WIDTH;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_addr;
    logic [1:0]      r_size;
    logic            r_write;
    logic [31:0]     r_wdt;
    logic [31:0]     r_rdt;
    logic            r_ackd_n;
    logic            r_err;
    logic [AW-1:0]   r_max;
    logic            r_exit;
    logic            r_sv;
    logic [7:0]      r_sc;
    logic [7:0]      r_mem [DEPTH];

    logic [AW-1:0]   w_eaddr;
    logic [2:0]      w_len;
    logic            w_below;
    logic [AW:0]     w_end;
    logic            w_above;
    logic [IW-1:0]   w_o0, w_o1, w_o2, w_o3;
    logic [31:0]     w_rdata;
    logic            w_is_stdout;
    logic            w_is_exit;
    logic            w_mmio;
    logic            w_err;
    logic            w_commit;

    // Effective first byte and length: halves/bytes are mirrored inside the word (big-endian lanes)
    always_comb begin
        w_eaddr = r_addr;
        w_len   = 3'd4;
        if (r_size[1]) begin
            w_eaddr = {r_addr[AW-1:2], 2'b11} - {{(AW-2){1'b0}}, r_addr[1:0]};
            w_len   = 3'd1;
        end else if (r_size[0]) begin
            w_eaddr = {r_addr[AW-1:2], 2'b10} - {{(AW-2){1'b0}}, r_addr[1:0]};
            w_len   = 3'd2;
        end
    end

    // Window check done one bit wider so a word straddling the top cannot wrap
    assign w_below = (w_eaddr < BASE_ADDR);
    assign w_end   = {1'b0, w_eaddr} + {{(AW-2){1'b0}}, w_len} - {1'b0, BASE_ADDR};
    assign w_above = (w_end > (AW+1)'(DEPTH));

    assign w_o0 = w_eaddr[IW-1:0] - BASE_ADDR[IW-1:0];
    assign w_o1 = w_o0 + IW'(1);
    assign w_o2 = w_o0 + IW'(2);
    assign w_o3 = w_o0 + IW'(3);

    // Load data, MSB first, zero-extended for half/byte
    always_comb begin
        w_rdata = 32'd0;
        if (r_size[1])      w_rdata = {24'd0, r_mem[w_o0]};
        else if (r_size[0]) w_rdata = {16'd0, r_mem[w_o0], r_mem[w_o1]};
        else                w_rdata = {r_mem[w_o0], r_mem[w_o1], r_mem[w_o2], r_mem[w_o3]};
    end

`ifdef DMEM_MMIO_EN
    assign w_is_stdout = r_write && r_size[1] && (r_addr == STDOUT_ADDR);
    assign w_is_exit   = r_write && (r_addr == EXIT_ADDR);
`else
    assign w_is_stdout = 1'b0;
    assign w_is_exit   = 1'b0;
`endif

    assign w_mmio   = w_is_stdout | w_is_exit;
    assign w_err    = !w_mmio && (w_below || w_above);
    assign w_commit = (r_state == S_ACK) && r_write && !w_err && !w_mmio;

    // Handshake FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_size   <= 2'd0;
            r_write  <= 1'b0;
            r_wdt    <= 32'd0;
            r_rdt    <= 32'd0;
            r_ackd_n <= 1'b1;
            r_err    <= 1'b0;
            r_max    <= '0;
            r_exit   <= 1'b0;
            r_sv     <= 1'b0;
            r_sc     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MREQ && !r_exit) begin
                        r_addr  <= DAD;
                        r_size  <= SIZE;
                        r_write <= WRITE;
                        r_wdt   <= WDT;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!MREQ) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state  <= S_ACK;
                        r_ackd_n <= 1'b0;
                        r_err    <= w_err;
                        r_rdt    <= (!r_write && !w_err && !w_mmio) ? w_rdata : 32'd0;
                        r_sv     <= w_is_stdout;
                        r_sc     <= w_is_stdout ? r_wdt[7:0] : 8'd0;
                        if (!w_err && !w_mmio && (r_addr > r_max))
                            r_max <= r_addr;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_ackd_n <= 1'b1;
                    r_rdt    <= 32'd0;
                    r_err    <= 1'b0;
                    r_sv     <= 1'b0;
                    r_sc     <= 8'd0;
                    if (w_is_exit)
                        r_exit <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Store commit on the edge that ends ACK; contents survive reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            if (r_size[1]) begin
                r_mem[w_o0] <= r_wdt[7:0];
            end else if (r_size[0]) begin
                r_mem[w_o0] <= r_wdt[15:8];
                r_mem[w_o1] <= r_wdt[7:0];
            end else begin
                r_mem[w_o0] <= r_wdt[31:24];
                r_mem[w_o1] <= r_wdt[23:16];
                r_mem[w_o2] <= r_wdt[15:8];
                r_mem[w_o3] <= r_wdt[7:0];
            end
        end
    end

    assign RDT          = r_rdt;
    assign ACKD_n       = r_ackd_n;
    assign ERR          = r_err;
    assign MAX_ADDR     = r_max;
    assign EXIT         = r_exit;
    assign STDOUT_VALID = r_sv;
    assign STDOUT_CHAR  = r_sc;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl; one instance at LATENCY=3
// and one at LATENCY=4, selected through a shared request bus.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mreq = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] dad = 32'd0;
    logic [31:0] wdt = 32'd0;
    logic        sel = 1'b0;

    logic [31:0] a_rdt, b_rdt, a_max, b_max;
    logic        a_ackd_n, b_ackd_n, a_err, b_err, a_exit, b_exit, a_sv, b_sv;
    logic [7:0]  a_sc, b_sc;

    logic [31:0] rdt, maxa;
    logic        ackd_n, err, ext, sv;
    logic [7:0]  sc;

    int n_vec = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [31:0] rdt;
        logic        err;
        logic        sv;
        logic [7:0]  sc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_ctrl #(.LATENCY(3)) u_dut_a (
        .clk(clk), .rst(rst), .MREQ(mreq & ~sel), .WRITE(write), .SIZE(size),
        .DAD(dad), .WDT(wdt), .RDT(a_rdt), .ACKD_n(a_ackd_n), .ERR(a_err),
        .MAX_ADDR(a_max), .EXIT(a_exit), .STDOUT_VALID(a_sv), .STDOUT_CHAR(a_sc)
    );

    dmem_ctrl #(.LATENCY(4)) u_dut_b (
        .clk(clk), .rst(rst), .MREQ(mreq & sel), .WRITE(write), .SIZE(size),
        .DAD(dad), .WDT(wdt), .RDT(b_rdt), .ACKD_n(b_ackd_n), .ERR(b_err),
        .MAX_ADDR(b_max), .EXIT(b_exit), .STDOUT_VALID(b_sv), .STDOUT_CHAR(b_sc)
    );

    assign rdt    = sel ? b_rdt    : a_rdt;
    assign ackd_n = sel ? b_ackd_n : a_ackd_n;
    assign err    = sel ? b_err    : a_err;
    assign maxa   = sel ? b_max    : a_max;
    assign ext    = sel ? b_exit   : a_exit;
    assign sv     = sel ? b_sv     : a_sv;
    assign sc     = sel ? b_sc     : a_sc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the ack, compare against the scoreboard
    task automatic req(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e_rdt, input logic e_err,
                       input logic e_sv, input logic [7:0] e_sc, input int lat);
        exp_t x;
        int   n;
        bit   got;
        x = '{rdt: e_rdt, err: e_err, sv: e_sv, sc: e_sc};
        sb.push_back(x);
        @(posedge clk); #1;
        mreq = 1'b1; write = wr; size = sz; dad = a; wdt = d;
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (!ackd_n) got = 1'b1;
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_latency", 32'(n), 32'(lat));
        x = sb.pop_front();
        chk("rdt", rdt, x.rdt);
        chk("err", 32'(err), 32'(x.err));
        chk("stdout_valid", 32'(sv), 32'(x.sv));
        chk("stdout_char", 32'(sc), 32'(x.sc));
        mreq = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ack_one_cycle", 32'(ackd_n), 32'd1);
    endtask

    // Count acknowledges over a window where none may occur
    task automatic no_ack(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!ackd_n) lows++;
        end
        chk(tag, 32'(lows), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ackd_n"}, 32'(ackd_n), 32'd1);
        chk({tag, "_rdt"}, rdt, 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_max"}, maxa, 32'd0);
        chk({tag, "_exit"}, 32'(ext), 32'd0);
        chk({tag, "_sv"}, 32'(sv), 32'd0);
        chk({tag, "_sc"}, 32'(sc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;

        // Word store / load, then mirrored half and byte lanes
        req(1'b1, 2'b00, 32'h0800_0010, 32'h1122_3344, 32'h0, 1'b0, 1'b0, 8'h0, 3);
        req(1'b0, 2'b00, 32'h0800_0010, 32'h0, 32'h1122_3344, 1'b0, 1'b0, 8'h0, 3);
        req(1'b0, 2'b01, 32'h0800_0012, 32'h0, 32'h0000_1122, 1'b0, 1'b0, 8'h0, 3);
        req(1'b0, 2'b10, 32'h0800_0013, 32'h0, 32'h0000_0011, 1'b0, 1'b0, 8'h0, 3);
        req(1'b0, 2'b01, 32'h0800_0010, 32'h0, 32'h0000_3344, 1'b0, 1'b0, 8'h0, 3);
        req(1'b0, 2'b10, 32'h0800_0010, 32'h0, 32'h0000_0044, 1'b0, 1'b0, 8'h0, 3);
        req(1'b0, 2'b11, 32'h0800_0011, 32'h0, 32'h0000_0033, 1'b0, 1'b0, 8'h0, 3);
        chk("max_after_loads", maxa, 32'h0800_0013);

        // Half store lands in bytes 12,13; byte store @11 lands in byte 12
        req(1'b1, 2'b01, 32'h0800_0010, 32'h0000_BEEF, 32'h0, 1'b0, 1'b0, 8'h0, 3);
        req(1'b1, 2'b10, 32'h0800_0011, 32'h0000_005A, 32'h0, 1'b0, 1'b0, 8'h0, 3);
        req(1'b0, 2'b00, 32'h0800_0010, 32'h0, 32'h1122_5AEF, 1'b0, 1'b0, 8'h0, 3);

        // Window boundaries
        req(1'b0, 2'b00, 32'h0800_FFFE, 32'h0, 32'h0, 1'b1, 1'b0, 8'h0, 3);
        chk("max_after_err", maxa, 32'h0800_0013);
        req(1'b0, 2'b10, 32'h07FF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0, 8'h0, 3);
        req(1'b1, 2'b00, 32'h0800_FFFC, 32'hA1B2_C3D4, 32'h0, 1'b0, 1'b0, 8'h0, 3);
        req(1'b0, 2'b10, 32'h0800_FFFF, 32'h0, 32'h0000_00A1, 1'b0, 1'b0, 8'h0, 3);
        chk("max_top", maxa, 32'h0800_FFFF);

        // Reset in the middle of WAIT on a store
        @(posedge clk); #1;
        mreq = 1'b1; write = 1'b1; size = 2'b00; dad = 32'h0800_0010; wdt = 32'hDEAD_BEEF;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; mreq = 1'b0;
        #2;
        chk_reset_outs("midwait_rst");
        rst = 1'b0;
        req(1'b0, 2'b00, 32'h0800_0010, 32'h0, 32'h1122_5AEF, 1'b0, 1'b0, 8'h0, 3);
        chk("max_post_rst", maxa, 32'h0800_0010);

        // LATENCY=4 instance: abort after one WAIT cycle
        sel = 1'b1;
        req(1'b1, 2'b00, 32'h0800_0020, 32'h0102_0304, 32'h0, 1'b0, 1'b0, 8'h0, 4);
        @(posedge clk); #1;
        mreq = 1'b1; write = 1'b1; size = 2'b00; dad = 32'h0800_0020; wdt = 32'hFFFF_FFFF;
        @(posedge clk);
        @(posedge clk); #1;
        mreq = 1'b0;
        no_ack("abort_noack", 8);
        req(1'b0, 2'b00, 32'h0800_0020, 32'h0, 32'h0102_0304, 1'b0, 1'b0, 8'h0, 4);
        sel = 1'b0;

`ifdef DMEM_MMIO_EN
        req(1'b1, 2'b10, 32'hF000_0000, 32'h0000_0041, 32'h0, 1'b0, 1'b1, 8'h41, 3);
        chk("stdout_drop", 32'(sv), 32'd0);
        chk("exit_before", 32'(ext), 32'd0);
        req(1'b1, 2'b00, 32'hFF00_0000, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 3);
        chk("exit_set", 32'(ext), 32'd1);
        @(posedge clk); #1;
        mreq = 1'b1; write = 1'b0; size = 2'b00; dad = 32'h0800_0010;
        no_ack("exit_noack", 10);
        mreq = 1'b0;
`else
        req(1'b1, 2'b10, 32'hF000_0000, 32'h0000_0041, 32'h0, 1'b1, 1'b0, 8'h0, 3);
        req(1'b1, 2'b00, 32'hFF00_0000, 32'h0, 32'h0, 1'b1, 1'b0, 8'h0, 3);
        chk("exit_off", 32'(ext), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
